mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 17, meaning the RAM is 2^RAM_ADDR_W bytes (128 KB).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the entry count of each of the TX FIFO and the RX FIFO; it is a power of two.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rdy_in, input, 1 bit: system ready; when low, all state is frozen.
REQ-006 SHALL have port mem_a, input, 32 bits: byte address driven by the CPU.
REQ-007 SHALL have port mem_dout, input, 8 bits: write byte driven by the CPU.
REQ-008 SHALL have port mem_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port mem_din, output, 8 bits: read byte returned to the CPU.
REQ-010 SHALL have ports rx_valid and rx_data, inputs, 1 bit and 8 bits: input byte from the UART side.
REQ-011 SHALL have port rx_ready, output, 1 bit: high when the RX FIFO is not full.
REQ-012 SHALL have ports tx_valid and tx_data, outputs, 1 bit and 8 bits: output byte toward the UART side.
REQ-013 SHALL have port tx_ready, input, 1 bit: the UART side accepts tx_data.
REQ-014 SHALL have port io_buffer_full, output, 1 bit: high when the TX FIFO holds FIFO_DEPTH-1 or more entries.
REQ-015 SHALL have port program_stop, output, 1 bit: sticky flag; set by a write to 0x30004.

Function
REQ-016 SHALL decode the address: mem_a[17:16]==2'b11 selects I/O; any other value selects RAM at mem_a[RAM_ADDR_W-1:0].
REQ-017 SHALL, on a RAM read, present the byte on mem_din on the cycle after the address is applied (registered, one-cycle latency).
REQ-018 SHALL, on a RAM write, update the byte at the edge on which mem_wr=1 is sampled; mem_din then holds its previous value.
REQ-019 SHALL, on a write to 0x30000 with a nonzero byte, push the byte into the TX FIFO; a write of 0x00 is ignored; a write while the FIFO is full is dropped.
REQ-020 SHALL, on a read of 0x30000, pop the RX FIFO and return its head on mem_din the next cycle; if the RX FIFO is empty, return 0x00 and pop nothing.
REQ-021 SHALL run a 32-bit cycle counter that increments every cycle with rdy_in=1 and wraps from 0xFFFFFFFF to 0.
REQ-022 SHALL, on a read of 0x30004, snapshot the counter and return snapshot[7:0]; reads of 0x30005, 0x30006 and 0x30007 return snapshot bytes 1, 2 and 3 respectively.
REQ-023 SHALL, on a write to 0x30004, set program_stop and push 0x00 into the TX FIFO (the terminator), bypassing the zero filter.
REQ-024 SHALL return 0x00 for reads of other I/O addresses and ignore writes to them.
REQ-025 SHALL complete a TX handshake when tx_valid and tx_ready are both high: pop one entry per cycle.
REQ-026 SHALL complete an RX handshake when rx_valid and rx_ready are both high: push one entry per cycle.
REQ-027 SHALL, on a simultaneous push and pop of one FIFO, keep the occupancy unchanged, including when the FIFO is full: a pop frees a slot in the same cycle.
REQ-028 SHALL implement each FIFO as a circular buffer with wrapping pointers of log2(FIFO_DEPTH) bits plus an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-029 SHALL, while rdy_in=0, ignore CPU accesses and hold the counter, FIFOs and mem_din; UART handshakes also stall (rx_ready=0, tx_valid=0).

Reset
REQ-030 SHALL, on rst_in high, asynchronously clear: mem_din=0x00, FIFO pointers and counts=0, tx_valid=0, rx_ready=0, counter=0, snapshot=0, program_stop=0.
REQ-031 SHALL make rx_ready=1 in the first cycle after rst_in deasserts.
REQ-032 SHALL discard any FIFO content when reset asserts mid-operation.
REQ-033 SHALL NOT reset RAM contents.

Structure
REQ-034 SHALL place the I/O address constants (IO_PORT 0x30000, IO_CLK 0x30004) and the I/O-select bit pattern in the shared defines file.
REQ-035 SHALL instantiate one sub-module, byte_fifo (parameterised depth, push/pop/full/empty/count), twice: once for TX and once for RX.
REQ-036 SHALL keep the RAM array inline as a behavioural memory.

Verification
REQ-037 SHALL cover RAM write then read: write 0xA5 to 0x00010, then read 0x00010 -> mem_din=0xA5 one cycle later.
REQ-038 SHALL cover TX output: writes of 0x41, 0x00 and 0x42 to 0x30000 with tx_ready=1 -> exactly 0x41 then 0x42 appear on tx_data.
REQ-039 SHALL cover TX back-pressure: tx_ready=0 with 4 pushes -> io_buffer_full=1 after the 3rd push, the 4th push is accepted, a 5th is dropped; releasing tx_ready drains 4 entries in order.
REQ-040 SHALL cover RX: push 0x31 via rx_valid, then two reads of 0x30000 -> 0x31, then 0x00.
REQ-041 SHALL cover the counter: counter preloaded to 0xFFFFFFFE, read 0x30004..0x30007 -> bytes of the snapshot; counter wraps to 0 two cycles after preload.
REQ-042 SHALL cover program stop and reset: write to 0x30004 -> program_stop=1 and 0x00 on tx_data; asserting rst_in mid-drain -> tx_valid=0 and program_stop=0 immediately.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and address decode for the memory / I/O responder.
// Holds the I/O register map and the I/O-select bit pattern.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_PORT = 32'h0003_0000;
    localparam logic [31:0] IO_CLK  = 32'h0003_0004;
    localparam logic [1:0]  IO_SEL  = 2'b11;

    typedef enum logic [2:0] {
        IO_R_NONE,
        IO_R_PORT,
        IO_R_CLK0,
        IO_R_CLK1,
        IO_R_CLK2,
        IO_R_CLK3
    } io_reg_e;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

    function automatic io_reg_e io_decode(input logic [31:0] addr);
        case (addr)
            IO_PORT:         return IO_R_PORT;
            IO_CLK:          return IO_R_CLK0;
            IO_CLK + 32'd1:  return IO_R_CLK1;
            IO_CLK + 32'd2:  return IO_R_CLK2;
            IO_CLK + 32'd3:  return IO_R_CLK3;
            default:         return IO_R_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Circular-buffer byte FIFO with occupancy count.
// A pop in the same cycle frees a slot, so push is accepted on full when popping.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-facing byte memory with memory-mapped UART FIFOs, cycle counter and stop flag.
// RAM reads and I/O reads return on mem_din one cycle after the address.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 17,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] CNT_RESET  = '0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        io_buffer_full,
    output logic        program_stop
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            r_ram [2**RAM_ADDR_W];
    logic [7:0]            r_mem_din;
    logic [31:0]           r_cnt;
    logic [23:0]           r_snap;
    logic                  r_prog_stop;

    logic                  w_is_io;
    io_reg_e               w_io_reg;
    logic                  w_cpu_rd;
    logic                  w_cpu_wr;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic [7:0]            w_rd_data;
    logic                  w_tx_push;
    logic [7:0]            w_tx_wdata;
    logic                  w_tx_pop;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [CW-1:0]         w_tx_count;
    logic                  w_rx_push;
    logic                  w_rx_pop;
    logic [7:0]            w_rx_head;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [CW-1:0]         w_rx_count_unused;

    assign w_is_io    = is_io(mem_a);
    assign w_io_reg   = io_decode(mem_a);
    assign w_cpu_rd   = rdy_in & ~mem_wr;
    assign w_cpu_wr   = rdy_in & mem_wr;
    assign w_ram_addr = mem_a[RAM_ADDR_W-1:0];

    // A write to the clock register pushes the terminator byte, bypassing the zero filter.
    assign w_tx_push  = w_cpu_wr & w_is_io &
                        (((w_io_reg == IO_R_PORT) & (mem_dout != 8'h00)) | (w_io_reg == IO_R_CLK0));
    assign w_tx_wdata = (w_io_reg == IO_R_CLK0) ? 8'h00 : mem_dout;
    assign w_tx_pop   = tx_valid & tx_ready;
    assign w_rx_push  = rx_valid & rx_ready;
    assign w_rx_pop   = w_cpu_rd & w_is_io & (w_io_reg == IO_R_PORT);

    assign tx_valid       = rdy_in & ~w_tx_empty;
    assign rx_ready       = rdy_in & ~rst_in & ~w_rx_full;
    assign io_buffer_full = (w_tx_count >= CW'(FIFO_DEPTH - 1));
    assign mem_din        = r_mem_din;
    assign program_stop   = r_prog_stop;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_tx_push),
        .i_data  (w_tx_wdata),
        .i_pop   (w_tx_pop),
        .o_data  (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (w_rx_push),
        .i_data  (rx_data),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count_unused)
    );

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_io) begin
            w_rd_data = r_ram[w_ram_addr];
        end else begin
            case (w_io_reg)
                IO_R_PORT: w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
                IO_R_CLK0: w_rd_data = r_cnt[7:0];
                IO_R_CLK1: w_rd_data = r_snap[7:0];
                IO_R_CLK2: w_rd_data = r_snap[15:8];
                IO_R_CLK3: w_rd_data = r_snap[23:16];
                default:   w_rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_cpu_wr && !w_is_io) r_ram[w_ram_addr] <= mem_dout;
    end

    // Only the upper three counter bytes are kept; byte 0 is returned live on the snapshot read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mem_din   <= 8'h00;
            r_cnt       <= CNT_RESET;
            r_snap      <= '0;
            r_prog_stop <= 1'b0;
        end else if (rdy_in) begin
            r_cnt <= r_cnt + 32'd1;
            if (w_cpu_rd) r_mem_din <= w_rd_data;
            if (w_cpu_rd && w_is_io && (w_io_reg == IO_R_CLK0)) r_snap <= r_cnt[31:8];
            if (w_cpu_wr && w_is_io && (w_io_reg == IO_R_CLK0)) r_prog_stop <= 1'b1;
        end
    end

endmodule
